uart_cmd_sys: RTL and testbench
===============================

Name: uart_cmd_sys

Overview:
- Single-clock UART-controlled register/ALU subsystem.
- Receives command frames on RX_IN and executes register-file writes, register reads and 8-bit ALU operations.
- Returns read data and ALU results as UART frames on TX_OUT.
- Top-level block of the low-power command system; UART RX, TX, controller, 16x8 register file and ALU all sit inside it.

Parameters:
- CLKS_PER_BIT, 8, REF_CLK cycles per UART bit (even, >=4). Applies to both RX and TX.
- RF_DEPTH, 16, register-file entries. Address uses the low log2(RF_DEPTH) bits of the address byte.

Ports:
- REF_CLK  input  1  sole clock; all logic rising-edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  UART serial input, idle high, asynchronous to REF_CLK.
- TX_OUT  output  1  UART serial output, idle high.
- parity_error  output  1  one-cycle pulse: received frame had bad parity.
- framing_error  output  1  one-cycle pulse: received frame had stop bit = 0.

Behaviour:
- Reset values: TX_OUT=1, parity_error=0, framing_error=0, all register-file entries=0x00, controller IDLE, RX/TX idle. A reset mid-frame aborts the RX or TX frame in progress.
- Frame format (RX and TX): start 0, 8 data bits LSB first, odd parity bit (data plus parity has an odd number of ones), stop 1. Each bit lasts CLKS_PER_BIT cycles.
- RX input path: RX_IN passes through a 2-flop synchronizer.
- RX start detection: in idle, a sampled 0 starts a frame.
- RX start check: after CLKS_PER_BIT/2 cycles the line is rechecked. If it is 1, the event is a glitch and RX returns to idle.
- RX bit sampling: each following bit is sampled every CLKS_PER_BIT cycles, at mid-bit.
- RX frame end: after the stop-bit sample, RX returns to idle immediately and can accept a new start on the next cycle.
- RX valid frame: parity OK and stop=1. RX pulses byte_valid for 1 cycle to the controller.
- RX parity failure: parity_error pulses 1 cycle at the stop sample. The byte is dropped.
- RX framing failure: framing_error pulses 1 cycle at the stop sample. The byte is dropped.
- RX both failures: both flags pulse together. Dropped bytes never change controller state.
- Controller states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ALU_FUN_ONLY.
- IDLE command decode:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to ALU_A.
  - 0xDD goes to ALU_FUN_ONLY.
  - Any other byte is ignored and the controller stays in IDLE.
- WR_ADDR: latch the address, go to WR_DATA. WR_DATA: write RF[addr]=byte, go to IDLE.
- RD_ADDR: queue RF[addr] for TX, go to IDLE.
- ALU_A: write RF[0]=byte. ALU_B: write RF[1]=byte. ALU_FUN and ALU_FUN_ONLY: compute with A=RF[0], B=RF[1], queue the 8-bit result, go to IDLE.
- ALU FUN[3:0] codes, result truncated to 8 bits:
  - 0 ADD.
  - 1 SUB (A-B, wraps mod 256).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT A.
  - 6 A==B ? 1 : 0.
  - 7 A>B ? 1 : 0.
  - 8 A>>1.
  - 9 A<<1.
  - Codes 10-15 give 0x00.
  - FUN[7:4] is ignored.
- A read or ALU result on the same cycle as a register write uses the post-write value of the previous command only. There are no same-cycle conflicts by construction.
- TX queue: TX has a 1-byte pending register. If TX is idle, a queued result starts transmission (start bit on TX_OUT) no later than 4 cycles after the stop-bit sample of the final command byte.
- TX busy: a queued byte waits in pending and is sent back-to-back after the current frame. If pending is already full, the new result is dropped.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: 11-bit frames with odd parity, generated on TX and checked on RX; parity_error is active.
- Undefined: 10-bit frames with no parity bit; parity_error is tied 0; framing check unchanged.
- The Test Plan below assumes UART_PARITY_EN is defined.

Test Plan:
- RST high for 2 cycles, then low -> TX_OUT=1, both error flags 0, idle line produces no TX activity.
- Frames 0xAA,0x05,0xEA then 0xBB,0x05 -> one TX frame carrying data 0xEA with parity 0 and stop 1; no error pulses.
- Frames 0xCC,0x0A,0x07,0x01 -> TX 0x03 (10-7); then 0xDD,0x02 -> TX 0x02 (0x0A AND 0x07).
- Frame 0xAA sent with wrong parity bit, then 0xBB,0x05 -> parity_error pulses once, bad byte ignored, read returns the current RF[5].
- Frame with stop bit 0 -> framing_error pulses once. A 2-cycle low glitch on an idle line -> no frame, no flags.
- RST asserted mid-RX and mid-TX -> TX_OUT immediately returns to 1, controller IDLE, RF cleared; a following 0xBB,0x05 returns 0x00.

Source files
------------

// File: rtl/uart_cmd_sys.sv
// uart_cmd_sys: UART-controlled 16x8 register file plus 8-bit ALU.
// Command bytes arrive on RX_IN; read data and ALU results go out on TX_OUT.
// Build option: define UART_PARITY_EN for 11-bit frames with odd parity.
// Without it, frames are 10 bits and parity_error is tied low.
module uart_cmd_sys #(
  parameter int CLKS_PER_BIT = 8,
  parameter int RF_DEPTH     = 16
) (
  input  logic REF_CLK,
  input  logic RST,
  input  logic RX_IN,
  output logic TX_OUT,
  output logic parity_error,
  output logic framing_error
);

  localparam int AW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_PARITY_EN
  localparam int TX_BITS = 11;
`else
  localparam int TX_BITS = 10;
`endif

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  localparam logic [2:0] C_IDLE         = 3'd0;
  localparam logic [2:0] C_WR_ADDR      = 3'd1;
  localparam logic [2:0] C_WR_DATA      = 3'd2;
  localparam logic [2:0] C_RD_ADDR      = 3'd3;
  localparam logic [2:0] C_ALU_A        = 3'd4;
  localparam logic [2:0] C_ALU_B        = 3'd5;
  localparam logic [2:0] C_ALU_FUN      = 3'd6;
  localparam logic [2:0] C_ALU_FUN_ONLY = 3'd7;

  // ---------------- receiver ----------------
  logic          rx_meta_reg, rx_sync_reg;
  logic [2:0]    rx_state_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic          byte_valid_reg;
  logic          framing_error_reg;
  logic          rx_par_ok;
`ifdef UART_PARITY_EN
  logic          rx_par_reg;
  logic          parity_error_reg;
  assign rx_par_ok    = ^{rx_shift_reg, rx_par_reg};
  assign parity_error = parity_error_reg;
`else
  assign rx_par_ok    = 1'b1;
  assign parity_error = 1'b0;
`endif
  assign framing_error = framing_error_reg;

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX_IN;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // RX frame FSM: start qualification at half-bit, then mid-bit sampling
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      rx_state_reg      <= RX_IDLE;
      rx_cnt_reg        <= '0;
      rx_bit_reg        <= '0;
      rx_shift_reg      <= '0;
      byte_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_reg        <= 1'b0;
      parity_error_reg  <= 1'b0;
`endif
    end else begin
      byte_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
`ifdef UART_PARITY_EN
      parity_error_reg  <= 1'b0;
`endif
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_reg <= RX_PAR;
`else
              rx_state_reg <= RX_STOP;
`endif
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_par_reg   <= rx_sync_reg;
            rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg        <= '0;
            rx_state_reg      <= RX_IDLE;
            byte_valid_reg    <= rx_sync_reg && rx_par_ok;
            framing_error_reg <= !rx_sync_reg;
`ifdef UART_PARITY_EN
            parity_error_reg  <= !rx_par_ok;
`endif
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- controller, register file, ALU ----------------
  logic [7:0]    rf_reg [RF_DEPTH];
  logic [2:0]    ctrl_state_reg, ctrl_state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          q_valid;
  logic [7:0]    q_data;

  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] fun);
    case (fun)
      4'd0:    alu_calc = a + b;
      4'd1:    alu_calc = a - b;
      4'd2:    alu_calc = a & b;
      4'd3:    alu_calc = a | b;
      4'd4:    alu_calc = a ^ b;
      4'd5:    alu_calc = ~a;
      4'd6:    alu_calc = {7'd0, a == b};
      4'd7:    alu_calc = {7'd0, a > b};
      4'd8:    alu_calc = a >> 1;
      4'd9:    alu_calc = a << 1;
      default: alu_calc = 8'h00;
    endcase
  endfunction

  // Command decode: one action per accepted byte; writes land at the next edge
  always_comb begin
    ctrl_state_next = ctrl_state_reg;
    addr_next       = addr_reg;
    wr_en           = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    q_valid         = 1'b0;
    q_data          = '0;
    if (byte_valid_reg) begin
      case (ctrl_state_reg)
        C_IDLE: begin
          case (rx_shift_reg)
            8'hAA:   ctrl_state_next = C_WR_ADDR;
            8'hBB:   ctrl_state_next = C_RD_ADDR;
            8'hCC:   ctrl_state_next = C_ALU_A;
            8'hDD:   ctrl_state_next = C_ALU_FUN_ONLY;
            default: ctrl_state_next = C_IDLE;
          endcase
        end
        C_WR_ADDR: begin
          addr_next       = rx_shift_reg[AW-1:0];
          ctrl_state_next = C_WR_DATA;
        end
        C_WR_DATA: begin
          wr_en           = 1'b1;
          wr_addr         = addr_reg;
          wr_data         = rx_shift_reg;
          ctrl_state_next = C_IDLE;
        end
        C_RD_ADDR: begin
          q_valid         = 1'b1;
          q_data          = rf_reg[rx_shift_reg[AW-1:0]];
          ctrl_state_next = C_IDLE;
        end
        C_ALU_A: begin
          wr_en           = 1'b1;
          wr_addr         = AW'(0);
          wr_data         = rx_shift_reg;
          ctrl_state_next = C_ALU_B;
        end
        C_ALU_B: begin
          wr_en           = 1'b1;
          wr_addr         = AW'(1);
          wr_data         = rx_shift_reg;
          ctrl_state_next = C_ALU_FUN;
        end
        default: begin
          q_valid         = 1'b1;
          q_data          = alu_calc(rf_reg[0], rf_reg[1], rx_shift_reg[3:0]);
          ctrl_state_next = C_IDLE;
        end
      endcase
    end
  end

  // Controller state and latched write address
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      ctrl_state_reg <= C_IDLE;
      addr_reg       <= '0;
    end else begin
      ctrl_state_reg <= ctrl_state_next;
      addr_reg       <= addr_next;
    end
  end

  // Register file: cleared on reset, single write port
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_reg[i] <= 8'h00;
    end else if (wr_en) begin
      rf_reg[wr_addr] <= wr_data;
    end
  end

  // ---------------- transmitter ----------------
  logic               pend_valid_reg;
  logic [7:0]         pend_data_reg;
  logic               tx_busy_reg;
  logic               tx_out_reg;
  logic [TX_BITS-1:0] tx_shift_reg;
  logic [CW-1:0]      tx_cnt_reg;
  logic [3:0]         tx_left_reg;
  logic               tx_done, tx_load;
  logic [TX_BITS-1:0] tx_frame;

  assign tx_done = tx_busy_reg && (tx_cnt_reg == BIT_LAST) && (tx_left_reg == 4'd0);
  assign tx_load = pend_valid_reg && (!tx_busy_reg || tx_done);
`ifdef UART_PARITY_EN
  assign tx_frame = {1'b1, ~^pend_data_reg, pend_data_reg, 1'b0};
`else
  assign tx_frame = {1'b1, pend_data_reg, 1'b0};
`endif
  assign TX_OUT = tx_out_reg;

  // One-byte pending slot; a result arriving while the slot is held is dropped
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= 8'h00;
    end else begin
      if (tx_load) pend_valid_reg <= 1'b0;
      if (q_valid && (!pend_valid_reg || tx_load)) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= q_data;
      end
    end
  end

  // TX shifter: loads straight from pending, back-to-back after a stop bit
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      tx_busy_reg  <= 1'b0;
      tx_out_reg   <= 1'b1;
      tx_shift_reg <= '1;
      tx_cnt_reg   <= '0;
      tx_left_reg  <= '0;
    end else if (tx_load) begin
      tx_busy_reg  <= 1'b1;
      tx_out_reg   <= tx_frame[0];
      tx_shift_reg <= tx_frame >> 1;
      tx_cnt_reg   <= '0;
      tx_left_reg  <= 4'(TX_BITS - 1);
    end else if (tx_busy_reg) begin
      if (tx_cnt_reg == BIT_LAST) begin
        tx_cnt_reg <= '0;
        if (tx_left_reg == 4'd0) begin
          tx_busy_reg <= 1'b0;
          tx_out_reg  <= 1'b1;
        end else begin
          tx_out_reg   <= tx_shift_reg[0];
          tx_shift_reg <= tx_shift_reg >> 1;
          tx_left_reg  <= tx_left_reg - 1'b1;
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sys.sv
// Testbench for uart_cmd_sys: drives command frames on RX_IN, decodes TX_OUT
// frames and compares them with results queued when the commands were sent.
// Follows the UART_PARITY_EN build option of the design.
module tb_uart_cmd_sys;

  localparam int CPB = 8;

  logic REF_CLK = 1'b0;
  logic RST     = 1'b1;
  logic RX_IN   = 1'b1;
  logic TX_OUT;
  logic parity_error;
  logic framing_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int exp_perr = 0;
  bit mon_busy = 1'b0;
  logic [7:0] exp_q[$];

  uart_cmd_sys #(.CLKS_PER_BIT(CPB), .RF_DEPTH(16)) dut (
    .REF_CLK      (REF_CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .TX_OUT       (TX_OUT),
    .parity_error (parity_error),
    .framing_error(framing_error)
  );

  always #5 REF_CLK = ~REF_CLK;

  always @(negedge REF_CLK) begin
    if (parity_error === 1'b1) perr_cnt++;
    if (framing_error === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge REF_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    RX_IN = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      RX_IN = d[k];
      tick(CPB);
    end
`ifdef UART_PARITY_EN
    RX_IN = (~^d) ^ bad_par;
    tick(CPB);
`endif
    if (bad_stop) begin
      RX_IN = 1'b0;
      tick(CPB / 2 + 2);
      RX_IN = 1'b1;
      tick(CPB / 2 - 2);
    end else begin
      RX_IN = 1'b1;
      tick(CPB);
    end
    $display("RX frame sent data=%02h bad_par=%0d bad_stop=%0d", d, bad_par, bad_stop);
    tick(2);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    tick(20);
    while ((exp_q.size() != 0 || mon_busy) && i < 3000) begin
      @(negedge REF_CLK);
      i++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge REF_CLK);
      if (RST !== 1'b0) ab = 1'b1;
    end
  endtask

  // TX monitor: decodes each frame at mid-bit and pops the scoreboard
  initial begin
    logic [7:0] d;
    logic       p, s;
    logic [8:0] expv;
    bit         ab;
    forever begin
      @(negedge REF_CLK);
      if (RST === 1'b0 && TX_OUT === 1'b0) begin
        mon_busy = 1'b1;
        ab = 1'b0;
        p = 1'b0;
        mon_wait(CPB / 2 - 1, ab);
        for (int k = 0; k < 8; k++) begin
          mon_wait(CPB, ab);
          d[k] = TX_OUT;
        end
`ifdef UART_PARITY_EN
        mon_wait(CPB, ab);
        p = TX_OUT;
`endif
        mon_wait(CPB, ab);
        s = TX_OUT;
        if (!ab) begin
          n_frames++;
          $display("TX frame received data=%02h parity=%0b stop=%0b", d, p, s);
          if (exp_q.size() > 0) expv = {1'b1, exp_q.pop_front()};
          else expv = 9'h000;
          check("tx_data", 32'({1'b1, d}), 32'(expv));
`ifdef UART_PARITY_EN
          check("tx_parity", 32'(p), 32'(~^d));
`endif
          check("tx_stop", 32'(s), 32'd1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  logic [7:0] fun_tab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h08, 8'h09, 8'h0A, 8'h0F, 8'h41, 8'hF4, 8'h06, 8'h07};
  logic [7:0] res_tab [16] = '{8'h11, 8'h03, 8'h02, 8'h0F, 8'h0D, 8'hF5, 8'h00, 8'h01,
                               8'h05, 8'h14, 8'h00, 8'h00, 8'h03, 8'h0D, 8'h00, 8'h01};

  initial begin
    int p0, f0, nf0, i;

    // Reset and idle line
    RST = 1'b1;
    RX_IN = 1'b1;
    tick(2);
    RST = 1'b0;
    @(negedge REF_CLK);
    check("reset_tx_out", 32'(TX_OUT), 32'd1);
    check("reset_parity_error", 32'(parity_error), 32'd0);
    check("reset_framing_error", 32'(framing_error), 32'd0);
    tick(60);
    check("idle_no_tx", 32'(n_frames), 32'd0);

    // Write RF[5]=0xEA, read it back
    send_byte(8'hAA, 0, 0);
    send_byte(8'h05, 0, 0);
    send_byte(8'hEA, 0, 0);
    send_byte(8'hBB, 0, 0);
    exp_q.push_back(8'hEA);
    send_byte(8'h05, 0, 0);
    drain("drain_read_ea");
    check("no_flags_write_read", 32'(perr_cnt + ferr_cnt), 32'd0);

    // Full ALU command: A=0x0A, B=0x07, SUB
    send_byte(8'hCC, 0, 0);
    send_byte(8'h0A, 0, 0);
    send_byte(8'h07, 0, 0);
    exp_q.push_back(8'h03);
    send_byte(8'h01, 0, 0);
    drain("drain_alu_sub");

    // Function-only ALU commands over every code with A=0x0A, B=0x07
    for (int k = 0; k < 14; k++) begin
      send_byte(8'hDD, 0, 0);
      exp_q.push_back(res_tab[k]);
      send_byte(fun_tab[k], 0, 0);
    end
    drain("drain_alu_table");

    // Boundaries: SUB wrap (3-5), GT false, EQ true
    send_byte(8'hCC, 0, 0);
    send_byte(8'h03, 0, 0);
    send_byte(8'h05, 0, 0);
    exp_q.push_back(8'hFE);
    send_byte(8'h01, 0, 0);
    send_byte(8'hDD, 0, 0);
    exp_q.push_back(8'h00);
    send_byte(fun_tab[15], 0, 0);
    send_byte(8'hCC, 0, 0);
    send_byte(8'h07, 0, 0);
    send_byte(8'h07, 0, 0);
    exp_q.push_back(8'h01);
    send_byte(fun_tab[14], 0, 0);
    drain("drain_alu_boundary");

`ifdef UART_PARITY_EN
    // Bad parity on 0xAA: dropped, then a read still works
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_byte(8'hAA, 1, 0);
    exp_perr++;
    check("parity_error_pulse", 32'(perr_cnt - p0), 32'd1);
    check("parity_no_framing", 32'(ferr_cnt - f0), 32'd0);
    send_byte(8'hBB, 0, 0);
    exp_q.push_back(8'hEA);
    send_byte(8'h05, 0, 0);
    drain("drain_after_parity");
`endif

    // Stop bit 0
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_byte(8'h33, 0, 1);
    tick(20);
    check("framing_error_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("framing_no_parity", 32'(perr_cnt - p0), 32'd0);

    // 2-cycle glitch while waiting for a read address
    send_byte(8'hBB, 0, 0);
    p0 = perr_cnt;
    f0 = ferr_cnt;
    nf0 = n_frames;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(150);
    check("glitch_no_flags", 32'(perr_cnt + ferr_cnt - p0 - f0), 32'd0);
    check("glitch_no_tx", 32'(n_frames - nf0), 32'd0);
    exp_q.push_back(8'hEA);
    send_byte(8'h05, 0, 0);
    drain("drain_after_glitch");

    // Reset during a TX frame
    send_byte(8'hBB, 0, 0);
    exp_q.push_back(8'hEA);
    send_byte(8'h05, 0, 0);
    i = 0;
    while (TX_OUT !== 1'b0 && i < 200) begin
      @(negedge REF_CLK);
      i++;
    end
    check("tx_started_before_reset", 32'(TX_OUT), 32'd0);
    tick(20);
    RST = 1'b1;
    tick(1);
    check("tx_out_high_on_reset", 32'(TX_OUT), 32'd1);
    tick(1);
    RST = 1'b0;
    exp_q.delete();
    drain("drain_after_tx_reset");

    // Reset during an RX frame with the controller mid-command
    send_byte(8'hAA, 0, 0);
    RX_IN = 1'b0;
    tick(CPB * 3);
    RST = 1'b1;
    tick(2);
    RX_IN = 1'b1;
    RST = 1'b0;
    tick(4);
    send_byte(8'hBB, 0, 0);
    exp_q.push_back(8'h00);
    send_byte(8'h05, 0, 0);
    drain("drain_after_rx_reset");

    check("parity_error_total", 32'(perr_cnt), 32'(exp_perr));
    check("tx_out_idle_end", 32'(TX_OUT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
